// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a prefetch FIFO: sequences the PC, reads a
// synchronous instruction memory and hands {pc, instruction} pairs to decode.
`timescale 1ns/1ps

module fetch_queue #(
    parameter int unsigned          ADDR_W      = 18,
    parameter int unsigned          INSTR_W     = 18,
    parameter int unsigned          PC_STEP     = 4,
    parameter int unsigned          LINK_OFFSET = 8,
    parameter int unsigned          DEPTH       = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pc_src,
    input  logic [ADDR_W-1:0]          wb,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         instruction,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [ADDR_W-1:0]          pc_8,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic               r_inflight;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];

    logic [CNT_W:0]     w_reserved;
    logic               w_valid;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;

    // The in-flight read holds a slot, so a returning response can never overflow.
    assign w_reserved = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_valid    = (r_count != '0);
    assign w_issue    = reset & ~pc_src & (w_reserved < (CNT_W+1)'(DEPTH));
    assign w_push     = r_inflight & ~pc_src;
    assign w_pop      = w_valid & out_ready & ~pc_src;

    assign imem_req   = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign out_valid  = w_valid;
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else if (pc_src) begin
            r_fetch_pc    <= wb;
            r_inflight    <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + ADDR_W'(PC_STEP);
            end
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_pc_mem[r_wptr]    <= r_inflight_pc;
            r_instr_mem[r_wptr] <= imem_rdata;
        end
    end

    always_comb begin
        instruction = '0;
        pc_out      = '0;
        pc_8        = '0;
        if (w_valid) begin
            instruction = r_instr_mem[r_rptr];
            pc_out      = r_pc_mem[r_rptr];
            pc_8        = r_pc_mem[r_rptr] + ADDR_W'(LINK_OFFSET);
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage with a prefetch buffer; successor of the single-register fetch stage.
- Sequences the PC, issues reads to a synchronous instruction memory and queues {pc, instruction} pairs in a FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Supports decode stalls and branch redirect/flush from writeback, and produces the PC+LINK_OFFSET link value per instruction.

Parameters:
- ADDR_W, 18, PC/address width.
- INSTR_W, 18, instruction width.
- PC_STEP, 4, PC increment per instruction.
- LINK_OFFSET, 8, offset added to an instruction's PC to form pc_8.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_src  in  1  branch redirect request (1 = take wb).
- wb  in  ADDR_W  redirect target address.
- imem_req  out  1  memory read strobe.
- imem_addr  out  ADDR_W  memory read address.
- imem_rdata  in  INSTR_W  read data; valid exactly 1 cycle after the accepted imem_req.
- out_ready  in  1  decode can accept this cycle.
- out_valid  out  1  FIFO head valid.
- instruction  out  INSTR_W  head instruction.
- pc_out  out  ADDR_W  head instruction PC.
- pc_8  out  ADDR_W  pc_out + LINK_OFFSET, modulo 2^ADDR_W.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset=0 at an edge), all cleared:
  - fetch_pc <= RESET_PC.
  - FIFO empty: count=0, out_valid=0.
  - In-flight flag cleared.
  - Same rules apply if reset is asserted mid-operation; any in-flight response is discarded.
- Output values:
  - When out_valid=0: instruction, pc_out and pc_8 are 0.
  - When out_valid=1: they reflect the FIFO head.
  - imem_req is combinational; imem_addr = fetch_pc at all times.
- Issue rule: imem_req=1 iff reset=1, pc_src=0 and (count + inflight) < DEPTH.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (wraps modulo 2^ADDR_W).
  - Otherwise inflight<=0.
- Response: when inflight=1 and pc_src=0, {inflight_pc, imem_rdata} is pushed at the end of that cycle. It becomes visible at the head on the next cycle; there is no bypass.
- Pop: on out_valid & out_ready the head is removed.
  - Simultaneous push and pop: count is unchanged.
  - A pop at count=0 is impossible, since out_valid=0.
- Latency:
  - First issue in the first cycle with reset=1 (cycle 0).
  - Data arrives at cycle 1; out_valid=1 at cycle 2.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Full: the reservation counts the in-flight read, so a push never overflows. A stalled decode fills the FIFO to DEPTH, after which imem_req=0.
- Redirect (pc_src=1 at cycle T), highest priority after reset:
  - FIFO flushed (count<=0).
  - In-flight response at T is dropped.
  - No issue at T; fetch_pc<=wb.
  - Any pop in cycle T is discarded, and out_ready is ignored.
  - Sequence: issue of wb at T+1, data at T+2, out_valid at T+3.
  - Back-to-back redirects: the last one wins.
- Read/write pointers are log2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, memory returns addr>>2: out_valid rises at cycle 2. pc_out then follows 0,4,8,12… with instruction 0,1,2,3…, pc_8 = pc_out+8, and one instruction per cycle.
- out_ready=0 from cycle 0: count rises to 4 and stays. imem_req=0 once count+inflight=4. Raising out_ready drains 0,4,8,12, then PC 16 follows with no gap beyond the 2-cycle refill.
- pc_src=1, wb=0x100 while count=3 and a read is in flight: at T+1 count=0 and imem_addr=0x100. At T+3 out_valid=1 with pc_out=0x100; the stale in-flight data is never output.
- Redirect in the same cycle as a pop (out_ready=1): the FIFO is empty afterwards and the popped entry is not repeated. Redirects at T and T+1 (wb=0x40, then 0x80): the first instruction seen has pc_out=0x80.
- fetch_pc near wrap (wb=0x3FFF8, ADDR_W=18): pc_out sequence is 0x3FFF8, 0x3FFFC, 0x00000; pc_8 for 0x3FFF8 is 0x00000.
- reset=0 mid-stream with FIFO at 2: next cycle count=0, out_valid=0, outputs 0. After release, fetch restarts from RESET_PC.
